// File: rtl/adder_vector_pkg.sv
// Shared types and constants for the adder operand vector source.
// corner_vec() builds the fixed corner-case operand table for any width.
package adder_vector_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CORNER,
        S_WALK,
        S_RANDOM,
        S_DONE
    } state_e;

    localparam logic [1:0] PH_CORNER = 2'd0;
    localparam logic [1:0] PH_WALK   = 2'd1;
    localparam logic [1:0] PH_RANDOM = 2'd2;
    localparam logic [1:0] PH_IDLE   = 2'd3;

    localparam int CORNER_COUNT = 8;

    // Fibonacci taps 64,63,61,60 as a bit mask over state[63:0]
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    // Returns {cin, a[63:0], b[63:0]}, operands masked to n bits
    function automatic logic [128:0] corner_vec(input logic [2:0] k,
                                                input int n);
        logic [63:0]  ones;
        logic [63:0]  alt5;
        logic [63:0]  alta;
        logic [63:0]  msb;
        logic [128:0] v;
        ones = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - n);
        alt5 = 64'h5555_5555_5555_5555 & ones;
        alta = 64'hAAAA_AAAA_AAAA_AAAA & ones;
        msb  = 64'd1 << (n - 1);
        v    = '0;
        unique case (k)
            3'd0: v = {1'b0, 64'd0, 64'd0};
            3'd1: v = {1'b1, 64'd0, 64'd0};
            3'd2: v = {1'b1, ones, 64'd0};
            3'd3: v = {1'b0, ones, ones};
            3'd4: v = {1'b1, ones, ones};
            3'd5: v = {1'b1, alt5, alta};
            3'd6: v = {1'b0, msb, msb};
            3'd7: v = {1'b0, ones, 64'd1};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/adder_vector_source_if.sv
// Valid/ready operand bundle between the vector source and the adder pair.
// The source drives the vector; the consumer drives ready.
interface adder_vector_source_if #(
    parameter int N = 64
) ();
    logic         valid;
    logic         ready;
    logic         cin;
    logic [N-1:0] a;
    logic [N-1:0] b;

    modport master (
        output valid,
        output cin,
        output a,
        output b,
        input  ready
    );

    modport slave (
        input  valid,
        input  cin,
        input  a,
        input  b,
        output ready
    );
endinterface

// File: rtl/lfsr64_step2.sv
// Combinational two-step advance of the 64-bit Fibonacci LFSR.
// step1_o feeds operand a, step2_o feeds operand b and the carry-in.
module lfsr64_step2
    import adder_vector_pkg::*;
(
    input  logic [63:0] state_i,
    output logic [63:0] step1_o,
    output logic [63:0] step2_o,
    output logic [63:0] next_o
);
    always_comb begin
        step1_o = {state_i[62:0], ^(state_i & LFSR_TAPS)};
        step2_o = {step1_o[62:0], ^(step1_o & LFSR_TAPS)};
        next_o  = step2_o;
    end
endmodule

// File: rtl/adder_vector_source.sv
// Stimulus source for adder DUVs: corner cases, carry-chain walk,
// then LFSR random operands, streamed over a valid/ready handshake.
module adder_vector_source
    import adder_vector_pkg::*;
#(
    parameter int          N          = 64,
    parameter int          NUM_RANDOM = 30000,
    parameter logic [63:0] SEED       = 64'h0123_4567_89AB_CDEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    adder_vector_source_if.master vec,
    output logic [1:0]            phase,
    output logic [31:0]           vec_idx,
    output logic                  done
);
    localparam logic [63:0] SEED_EFF    = (SEED == 64'd0) ? 64'd1 : SEED;
    localparam logic [31:0] CORNER_LAST = 32'(CORNER_COUNT - 1);
    localparam logic [31:0] WALK_LAST   = 32'(N);
    localparam logic [31:0] RAND_LAST   = 32'(NUM_RANDOM - 1);

    state_e       state_q, state_d;
    logic [31:0]  k_q, k_d;
    logic [31:0]  idx_q, idx_d;
    logic         valid_q, valid_d;
    logic         done_q, done_d;
    logic         cin_q, cin_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [63:0]  lfsr_q, lfsr_d;

    logic [63:0]  s1, s2, s_next;
    logic [2:0]   cidx;
    logic [128:0] cv;
    logic         xfer;
    logic         unused_bits;

    lfsr64_step2 u_step (
        .state_i (lfsr_q),
        .step1_o (s1),
        .step2_o (s2),
        .next_o  (s_next)
    );

    // Outside CORNER the table lookup serves the start load (entry 0)
    assign cidx = (state_q == S_CORNER) ? (k_q[2:0] + 3'd1) : 3'd0;
    assign cv   = corner_vec(cidx, N);
    assign xfer = valid_q & vec.ready;

    assign unused_bits = ^{cv, s1};

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        done_d  = done_q;
        cin_d   = cin_q;
        a_d     = a_q;
        b_d     = b_q;
        lfsr_d  = lfsr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_CORNER;
                    k_d     = '0;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    done_d  = 1'b0;
                    cin_d   = cv[128];
                    a_d     = cv[64 +: N];
                    b_d     = cv[0 +: N];
                    lfsr_d  = SEED_EFF;
                end
            end
            S_CORNER: begin
                if (xfer) begin
                    idx_d = idx_q + 32'd1;
                    if (k_q == CORNER_LAST) begin
                        state_d = S_WALK;
                        k_d     = '0;
                        cin_d   = 1'b0;
                        a_d     = '0;
                        b_d     = N'(1);
                    end else begin
                        k_d   = k_q + 32'd1;
                        cin_d = cv[128];
                        a_d   = cv[64 +: N];
                        b_d   = cv[0 +: N];
                    end
                end
            end
            S_WALK: begin
                if (xfer) begin
                    idx_d = idx_q + 32'd1;
                    if (k_q == WALK_LAST) begin
                        k_d = '0;
                        if (NUM_RANDOM == 0) begin
                            state_d = S_DONE;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_RANDOM;
                            cin_d   = s2[63];
                            a_d     = s1[N-1:0];
                            b_d     = s2[N-1:0];
                            lfsr_d  = s_next;
                        end
                    end else begin
                        // Each step lengthens the carry ripple by one bit
                        k_d = k_q + 32'd1;
                        a_d = {a_q[N-2:0], 1'b1};
                    end
                end
            end
            S_RANDOM: begin
                if (xfer) begin
                    idx_d = idx_q + 32'd1;
                    if (k_q == RAND_LAST) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        k_d    = k_q + 32'd1;
                        cin_d  = s2[63];
                        a_d    = s1[N-1:0];
                        b_d    = s2[N-1:0];
                        lfsr_d = s_next;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            cin_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            lfsr_q  <= SEED_EFF;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            cin_q   <= cin_d;
            a_q     <= a_d;
            b_q     <= b_d;
            lfsr_q  <= lfsr_d;
        end
    end

    always_comb begin
        phase = PH_IDLE;
        case (state_q)
            S_CORNER: phase = PH_CORNER;
            S_WALK:   phase = PH_WALK;
            S_RANDOM: phase = PH_RANDOM;
            default:  phase = PH_IDLE;
        endcase
    end

    assign vec.valid = valid_q;
    assign vec.cin   = cin_q;
    assign vec.a     = a_q;
    assign vec.b     = b_q;
    assign vec_idx   = idx_q;
    assign done      = done_q;
endmodule

// File: tb/tb_adder_vector_source.sv
// Directed bench for adder_vector_source: corner table, walk, backpressure,
// reset abort, completion timing and LFSR determinism against a local model.
module tb_adder_vector_source;
    logic clk;
    logic rst_a, start_a;
    logic rst_b, start_b;
    logic rst_c, start_c;
    logic [1:0]  phase_a, phase_b, phase_c;
    logic [31:0] idx_a, idx_b, idx_c;
    logic        done_a, done_b, done_c;

    int checks;
    int fails;

    adder_vector_source_if #(.N(64)) if_a ();
    adder_vector_source_if #(.N(8))  if_b ();
    adder_vector_source_if #(.N(8))  if_c ();

    adder_vector_source #(.N(64), .NUM_RANDOM(3)) u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .vec(if_a),
        .phase(phase_a), .vec_idx(idx_a), .done(done_a)
    );
    adder_vector_source #(.N(8), .NUM_RANDOM(10), .SEED(64'd1)) u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .vec(if_b),
        .phase(phase_b), .vec_idx(idx_b), .done(done_b)
    );
    adder_vector_source #(.N(8), .NUM_RANDOM(10), .SEED(64'd0)) u_c (
        .clk(clk), .rst(rst_c), .start(start_c), .vec(if_c),
        .phase(phase_c), .vec_idx(idx_c), .done(done_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cin;
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  ph;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] lstep(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

    task automatic rnd_vec(input logic [63:0] seed, input int j,
                           output logic [63:0] ea, output logic [63:0] eb,
                           output logic ec);
        logic [63:0] s;
        s  = seed;
        ea = '0;
        eb = '0;
        ec = 1'b0;
        for (int i = 0; i <= j; i++) begin
            s  = lstep(s);
            ea = s;
            s  = lstep(s);
            eb = s;
            ec = s[63];
        end
    endtask

    initial begin
        vec_t        ctab[9];
        logic [7:0]  wtab[9];
        logic [63:0] ea, eb;
        logic        ec;
        logic [64:0] s65;
        logic [8:0]  s9;
        int          ticks;
        int          rnd_seen;

        checks = 0;
        fails  = 0;

        ctab[0] = '{1'b0, 64'd0, 64'd0, 2'd0};
        ctab[1] = '{1'b1, 64'd0, 64'd0, 2'd0};
        ctab[2] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2'd0};
        ctab[3] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_FFFF, 2'd0};
        ctab[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_FFFF, 2'd0};
        ctab[5] = '{1'b1, 64'h5555_5555_5555_5555,
                    64'hAAAA_AAAA_AAAA_AAAA, 2'd0};
        ctab[6] = '{1'b0, 64'h8000_0000_0000_0000,
                    64'h8000_0000_0000_0000, 2'd0};
        ctab[7] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'd0};
        ctab[8] = '{1'b0, 64'd0, 64'd1, 2'd1};

        wtab = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F,
                 8'h1F, 8'h3F, 8'h7F, 8'hFF};

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        if_a.ready = 1'b0; if_b.ready = 1'b0; if_c.ready = 1'b0;
        tick();
        tick();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        chk("rst_valid", if_a.valid, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_phase", phase_a, 2'd3);
        chk("rst_idx", idx_a, 32'd0);
        chk("rst_ab", {if_a.cin, if_a.a, if_a.b}, '0);

        // ---- N=64 corner table and completion timing ----
        if_a.ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        ticks = 0;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("c%0d_idx", i), idx_a, 32'(i));
            chk($sformatf("c%0d_valid", i), if_a.valid, 1'b1);
            chk($sformatf("c%0d_phase", i), phase_a, ctab[i].ph);
            chk($sformatf("c%0d_cin", i), if_a.cin, ctab[i].cin);
            chk($sformatf("c%0d_a", i), if_a.a, ctab[i].a);
            chk($sformatf("c%0d_b", i), if_a.b, ctab[i].b);
            if (i == 2) begin
                s65 = {1'b0, if_a.a} + {1'b0, if_a.b} + 65'(if_a.cin);
                chk("c2_sum", s65, {1'b1, 64'd0});
            end
            tick();
            ticks++;
        end
        rnd_seen = 0;
        while (!done_a && ticks < 200) begin
            if (if_a.valid && idx_a >= 32'd73 && idx_a <= 32'd75) begin
                rnd_vec(64'h0123_4567_89AB_CDEF, int'(idx_a) - 73,
                        ea, eb, ec);
                chk("a_rnd_a", if_a.a, ea);
                chk("a_rnd_b", if_a.b, eb);
                chk("a_rnd_cin", if_a.cin, ec);
                chk("a_rnd_phase", phase_a, 2'd2);
                rnd_seen++;
            end
            start_a = (ticks == 40 || ticks == 74);
            tick();
            start_a = 1'b0;
            ticks++;
        end
        chk("a_done_cycles", 32'(ticks), 32'd76);
        chk("a_done", done_a, 1'b1);
        chk("a_done_valid", if_a.valid, 1'b0);
        chk("a_done_idx", idx_a, 32'd76);
        chk("a_done_phase", phase_a, 2'd3);
        chk("a_rnd_seen", 32'(rnd_seen), 32'd3);

        // ---- N=8 backpressure, walk, reset abort ----
        if_b.ready = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_start_idx", idx_b, 32'd0);
        chk("b_start_valid", if_b.valid, 1'b1);
        tick();
        tick();
        if_b.ready = 1'b0;
        chk("bp_pre", {if_b.cin, if_b.a, if_b.b, idx_b[7:0]},
            {1'b1, 8'hFF, 8'h00, 8'd2});
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("bp_stall%0d", i),
                {if_b.valid, if_b.cin, if_b.a, if_b.b, idx_b[7:0]},
                {1'b1, 1'b1, 8'hFF, 8'h00, 8'd2});
        end
        if_b.ready = 1'b1;
        tick();
        chk("bp_post", {if_b.cin, if_b.a, if_b.b, idx_b[7:0]},
            {1'b0, 8'hFF, 8'hFF, 8'd3});
        tick();
        chk("bp_idx4", {if_b.cin, if_b.a, if_b.b, idx_b[7:0]},
            {1'b1, 8'hFF, 8'hFF, 8'd4});

        for (int n = 0; n < 20 && idx_b != 32'd8; n++) tick();
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("w%0d_idx", k), idx_b, 32'(8 + k));
            chk($sformatf("w%0d_phase", k), phase_b, 2'd1);
            chk($sformatf("w%0d_vec", k), {if_b.cin, if_b.a, if_b.b},
                {1'b0, wtab[k], 8'h01});
            if (k == 8) begin
                s9 = {1'b0, if_b.a} + {1'b0, if_b.b} + 9'(if_b.cin);
                chk("w8_sum", s9, 9'h100);
            end
            tick();
        end
        rnd_vec(64'd1, 0, ea, eb, ec);
        chk("b_rnd0_idx", idx_b, 32'd17);
        chk("b_rnd0_phase", phase_b, 2'd2);
        chk("b_rnd0", {if_b.cin, if_b.a, if_b.b}, {ec, ea[7:0], eb[7:0]});

        for (int n = 0; n < 10 && idx_b != 32'd20; n++) tick();
        chk("b_pre_rst_idx", idx_b, 32'd20);
        rst_b = 1'b1;
        tick();
        tick();
        rst_b = 1'b0;
        chk("b_rst", {if_b.valid, done_b, phase_b, idx_b},
            {1'b0, 1'b0, 2'd3, 32'd0});
        tick();
        chk("b_idle_hold", if_b.valid, 1'b0);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_restart", {if_b.valid, phase_b, idx_b, if_b.cin, if_b.a,
            if_b.b}, {1'b1, 2'd0, 32'd0, 1'b0, 8'd0, 8'd0});
        for (int n = 0; n < 40 && idx_b != 32'd17; n++) tick();
        chk("b_rerun_rnd0", {idx_b, if_b.cin, if_b.a, if_b.b},
            {32'd17, ec, ea[7:0], eb[7:0]});

        // ---- SEED=0 behaves as SEED=1 over the whole random phase ----
        if_c.ready = 1'b1;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        for (int n = 0; n < 40 && idx_c != 32'd17; n++) tick();
        for (int j = 0; j < 10; j++) begin
            rnd_vec(64'd1, j, ea, eb, ec);
            chk($sformatf("s0_rnd%0d", j),
                {if_c.valid, idx_c, if_c.cin, if_c.a, if_c.b},
                {1'b1, 32'(17 + j), ec, ea[7:0], eb[7:0]});
            tick();
        end
        chk("c_done", {done_c, if_c.valid, idx_c, phase_c},
            {1'b1, 1'b0, 32'd27, 2'd3});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
